// File: rtl/packetmem_sched_pkg.sv
// Shared types and default widths for the packet-memory buffer scheduler.
//   agent_state_t : per-agent ownership state (IDLE / OWN)
//   DEF_SEL_WIDTH : default buffer-index width
//   DEF_LEN_WIDTH : default packet byte-length width (0..4096)
//   N_BUFS_MAX    : largest supported buffer count
package packetmem_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } agent_state_t;

  localparam int unsigned DEF_SEL_WIDTH = 2;
  localparam int unsigned DEF_LEN_WIDTH = 13;
  localparam int unsigned N_BUFS_MAX    = 4;

endpackage

// File: rtl/sched_idx_fifo.sv
// Small FIFO of buffer indices, used for the CPU and forwarder queues.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   empty_o       : queue holds no entries
//   head_o        : oldest entry; a push into an empty queue shows up next cycle
module sched_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    do_push  = push_i && (cnt_q != CntW'(Depth));
    do_pop   = pop_i && (cnt_q != '0);
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/packetmem_sched.sv
// Buffer-ownership scheduler: hands packet buffers snooper -> CPU -> forwarder -> free pool.
// A CPU reject returns the buffer straight to the free pool.
// Ports:
//   clk, rst (async, active-low)
//   snooper_done/snooper_len       : snooper finished its buffer, with its byte length
//   ready_for_snooper/snooper_sel  : snooper grant
//   cpu_acc/cpu_rej                : CPU verdict pulses
//   ready_for_cpu/cpu_sel/cpu_len  : CPU grant and stored length
//   forwarder_done                 : forwarder finished
//   ready_for_forwarder/fwd_sel/fwd_len : forwarder grant and stored length
//   proto_err                      : sticky protocol-violation flag
// Optional macro PACKETMEM_SCHED_STATS_EN adds saturating 32-bit counters
//   stat_rx, stat_acc, stat_rej of legal handshakes.
module packetmem_sched
  import packetmem_sched_pkg::*;
#(
  parameter int unsigned N_BUFS    = 3,
  parameter int unsigned SEL_WIDTH = DEF_SEL_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 snooper_done,
  input  logic [LEN_WIDTH-1:0] snooper_len,
  output logic                 ready_for_snooper,
  output logic [SEL_WIDTH-1:0] snooper_sel,
  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  output logic                 ready_for_cpu,
  output logic [SEL_WIDTH-1:0] cpu_sel,
  output logic [LEN_WIDTH-1:0] cpu_len,
  input  logic                 forwarder_done,
  output logic                 ready_for_forwarder,
  output logic [SEL_WIDTH-1:0] fwd_sel,
  output logic [LEN_WIDTH-1:0] fwd_len,
  output logic                 proto_err
`ifdef PACKETMEM_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_rx,
  output logic [31:0]          stat_acc,
  output logic [31:0]          stat_rej
`endif
);

  agent_state_t snp_st_q, snp_st_d, cpu_st_q, cpu_st_d, fwd_st_q, fwd_st_d;
  logic [SEL_WIDTH-1:0] snooper_sel_q, snooper_sel_d, cpu_sel_q, cpu_sel_d, fwd_sel_q, fwd_sel_d;
  logic [LEN_WIDTH-1:0] cpu_len_q, cpu_len_d, fwd_len_q, fwd_len_d;
  logic [LEN_WIDTH-1:0] len_q [N_BUFS];
  logic [LEN_WIDTH-1:0] len_d [N_BUFS];
  logic [N_BUFS-1:0]    free_q, free_d, free_set, free_clr, low_oh;
  logic [SEL_WIDTH-1:0] low_idx, cpu_head, fwd_head;
  logic [LEN_WIDTH-1:0] cpu_head_len, fwd_head_len;
  logic                 proto_err_q, proto_err_d, viol;
  logic                 cpu_push, cpu_pop, cpu_empty, fwd_push, fwd_pop, fwd_empty;

  function automatic logic [N_BUFS-1:0] idx2oh(input logic [SEL_WIDTH-1:0] idx);
    logic [N_BUFS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(N_BUFS); i++) begin
      if (idx == SEL_WIDTH'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  sched_idx_fifo #(.Depth(N_BUFS), .Width(SEL_WIDTH)) u_cpu_q (
    .clk_i(clk), .rst_ni(rst), .push_i(cpu_push), .push_data_i(snooper_sel_q),
    .pop_i(cpu_pop), .empty_o(cpu_empty), .head_o(cpu_head)
  );

  sched_idx_fifo #(.Depth(N_BUFS), .Width(SEL_WIDTH)) u_fwd_q (
    .clk_i(clk), .rst_ni(rst), .push_i(fwd_push), .push_data_i(cpu_sel_q),
    .pop_i(fwd_pop), .empty_o(fwd_empty), .head_o(fwd_head)
  );

  // Lowest free buffer, both as index and as one-hot.
  always_comb begin
    logic found;
    found   = 1'b0;
    low_idx = '0;
    for (int i = 0; i < int'(N_BUFS); i++) begin
      if (free_q[i] && !found) begin
        low_idx = SEL_WIDTH'(i);
        found   = 1'b1;
      end
    end
    low_oh = free_q & (~free_q + N_BUFS'(1));
  end

  always_comb begin
    cpu_head_len = '0;
    fwd_head_len = '0;
    for (int i = 0; i < int'(N_BUFS); i++) begin
      if (cpu_head == SEL_WIDTH'(i)) cpu_head_len = len_q[i];
      if (fwd_head == SEL_WIDTH'(i)) fwd_head_len = len_q[i];
    end
  end

  always_comb begin
    snp_st_d      = snp_st_q;
    cpu_st_d      = cpu_st_q;
    fwd_st_d      = fwd_st_q;
    snooper_sel_d = snooper_sel_q;
    cpu_sel_d     = cpu_sel_q;
    cpu_len_d     = cpu_len_q;
    fwd_sel_d     = fwd_sel_q;
    fwd_len_d     = fwd_len_q;
    len_d         = len_q;
    free_set      = '0;
    free_clr      = '0;
    cpu_push      = 1'b0;
    cpu_pop       = 1'b0;
    fwd_push      = 1'b0;
    fwd_pop       = 1'b0;
    viol          = 1'b0;

    if (snp_st_q == OWN) begin
      if (snooper_done) begin
        for (int i = 0; i < int'(N_BUFS); i++) begin
          if (snooper_sel_q == SEL_WIDTH'(i)) len_d[i] = snooper_len;
        end
        cpu_push = 1'b1;
        snp_st_d = IDLE;
      end
    end else begin
      viol = viol | snooper_done;
      if (|free_q) begin
        snp_st_d      = OWN;
        snooper_sel_d = low_idx;
        free_clr      = low_oh;
      end
    end

    if (cpu_st_q == OWN) begin
      // Simultaneous acc/rej is a violation; the reject takes effect.
      viol = viol | (cpu_acc & cpu_rej);
      if (cpu_rej) begin
        free_set = free_set | idx2oh(cpu_sel_q);
        cpu_st_d = IDLE;
      end else if (cpu_acc) begin
        fwd_push = 1'b1;
        cpu_st_d = IDLE;
      end
    end else begin
      viol = viol | cpu_acc | cpu_rej;
      if (!cpu_empty) begin
        cpu_pop   = 1'b1;
        cpu_st_d  = OWN;
        cpu_sel_d = cpu_head;
        cpu_len_d = cpu_head_len;
      end
    end

    if (fwd_st_q == OWN) begin
      if (forwarder_done) begin
        free_set = free_set | idx2oh(fwd_sel_q);
        fwd_st_d = IDLE;
      end
    end else begin
      viol = viol | forwarder_done;
      if (!fwd_empty) begin
        fwd_pop   = 1'b1;
        fwd_st_d  = OWN;
        fwd_sel_d = fwd_head;
        fwd_len_d = fwd_head_len;
      end
    end

    // Granted (cleared) bits were free; released (set) bits were held, so they never overlap.
    free_d      = (free_q & ~free_clr) | free_set;
    proto_err_d = proto_err_q | viol;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snp_st_q      <= IDLE;
      cpu_st_q      <= IDLE;
      fwd_st_q      <= IDLE;
      snooper_sel_q <= '0;
      cpu_sel_q     <= '0;
      cpu_len_q     <= '0;
      fwd_sel_q     <= '0;
      fwd_len_q     <= '0;
      free_q        <= '1;
      proto_err_q   <= 1'b0;
      for (int i = 0; i < int'(N_BUFS); i++) begin
        len_q[i] <= '0;
      end
    end else begin
      snp_st_q      <= snp_st_d;
      cpu_st_q      <= cpu_st_d;
      fwd_st_q      <= fwd_st_d;
      snooper_sel_q <= snooper_sel_d;
      cpu_sel_q     <= cpu_sel_d;
      cpu_len_q     <= cpu_len_d;
      fwd_sel_q     <= fwd_sel_d;
      fwd_len_q     <= fwd_len_d;
      free_q        <= free_d;
      proto_err_q   <= proto_err_d;
      len_q         <= len_d;
    end
  end

  assign ready_for_snooper   = (snp_st_q == OWN);
  assign ready_for_cpu       = (cpu_st_q == OWN);
  assign ready_for_forwarder = (fwd_st_q == OWN);
  assign snooper_sel         = snooper_sel_q;
  assign cpu_sel             = cpu_sel_q;
  assign cpu_len             = cpu_len_q;
  assign fwd_sel             = fwd_sel_q;
  assign fwd_len             = fwd_len_q;
  assign proto_err           = proto_err_q;

`ifdef PACKETMEM_SCHED_STATS_EN
  logic [31:0] stat_rx_q, stat_acc_q, stat_rej_q;
  logic        rx_hs, acc_hs, rej_hs;

  assign rx_hs  = (snp_st_q == OWN) && snooper_done;
  assign acc_hs = (cpu_st_q == OWN) && cpu_acc && !cpu_rej;
  assign rej_hs = (cpu_st_q == OWN) && cpu_rej && !cpu_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rx_q  <= '0;
      stat_acc_q <= '0;
      stat_rej_q <= '0;
    end else begin
      if (rx_hs && (stat_rx_q != '1)) stat_rx_q <= stat_rx_q + 32'd1;
      if (acc_hs && (stat_acc_q != '1)) stat_acc_q <= stat_acc_q + 32'd1;
      if (rej_hs && (stat_rej_q != '1)) stat_rej_q <= stat_rej_q + 32'd1;
    end
  end

  assign stat_rx  = stat_rx_q;
  assign stat_acc = stat_acc_q;
  assign stat_rej = stat_rej_q;
`endif

endmodule

// File: doc/packetmem_sched.md
Name: packetmem_sched

Overview:
- Buffer-ownership scheduler for the packet-filter pipeline.
- Owns N_BUFS packet-memory buffers and passes each one in order: snooper -> CPU -> forwarder, then back to the free pool.
- A buffer the CPU rejects goes straight back to the free pool.
- Drives the buffer-select muxes of the packet memories and the ready/done handshakes of all three agents.

Parameters:
- N_BUFS, 3: number of packet buffers. Legal range 2..4.
- SEL_WIDTH, 2: buffer-index width. Must satisfy 2**SEL_WIDTH >= N_BUFS.
- LEN_WIDTH, 13: packet byte-length width (0..4096 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- snooper_done  in  1  1-cycle pulse: current snooper buffer is filled
- snooper_len  in  LEN_WIDTH  byte length, sampled with snooper_done
- ready_for_snooper  out  1  snooper owns buffer snooper_sel
- snooper_sel  out  SEL_WIDTH  buffer index granted to snooper
- cpu_acc  in  1  1-cycle pulse: accept packet
- cpu_rej  in  1  1-cycle pulse: reject packet
- ready_for_cpu  out  1  CPU owns buffer cpu_sel
- cpu_sel  out  SEL_WIDTH  buffer index granted to CPU
- cpu_len  out  LEN_WIDTH  stored length of cpu_sel
- forwarder_done  in  1  1-cycle pulse: forwarding finished
- ready_for_forwarder  out  1  forwarder owns buffer fwd_sel
- fwd_sel  out  SEL_WIDTH  buffer index granted to forwarder
- fwd_len  out  LEN_WIDTH  stored length of fwd_sel
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- All outputs are registered.
- Reset values: every ready_* = 0; every *_sel = 0; every *_len = 0; proto_err = 0. All buffers are in the free bitmap; both queues are empty.
- Per-agent state is a 2-state FSM, IDLE / OWN. ready_for_X = (state == OWN).
- Snooper, IDLE -> OWN: when the free bitmap is non-zero. Grant the lowest free index, clear its free bit, load snooper_sel.
- CPU, IDLE -> OWN: when cpu_q is non-empty. Pop the head, load cpu_sel and cpu_len.
- Forwarder, IDLE -> OWN: when fwd_q is non-empty. Pop the head, load fwd_sel and fwd_len.
- Grant latency: ready_for_X rises on the clock edge after the grant condition is first true while IDLE.
- snooper_done while OWN: store snooper_len in len[snooper_sel], push snooper_sel to cpu_q, go IDLE.
- cpu_acc while OWN: push cpu_sel to fwd_q, go IDLE.
- cpu_rej while OWN: set the free bit of cpu_sel, go IDLE.
- forwarder_done while OWN: set the free bit of fwd_sel, go IDLE.
- In every case ready_X drops on the edge that samples the done pulse. The earliest re-grant is 1 cycle later, so ready is low for at least 1 cycle between packets.
- Queues:
  - cpu_q and fwd_q are FIFOs of depth N_BUFS. They cannot overflow because each buffer index exists exactly once.
  - Same-cycle push and pop are legal. The popped entry is the old head; a push into an empty queue becomes visible the next cycle.
- Free bitmap: a reject and a forwarder_done in the same cycle both set their bits.
- Ordering: packets reach the forwarder in snooper completion order. Rejected packets are removed without reordering the rest.
- Back-pressure: when every buffer is held or queued, ready_for_snooper stays 0 until a buffer is freed. No packet is dropped.
- Protocol violations set proto_err (sticky until reset) and change no other state:
  - a done/acc/rej pulse while that agent is IDLE;
  - cpu_acc and cpu_rej high together. In that case the reject wins (buffer freed) and proto_err is set.
- Reset mid-operation: immediate asynchronous return to the reset state. Packets in flight are discarded.

Optional Feature:
- Macro: PACKETMEM_SCHED_STATS_EN.
- When defined, adds three 32-bit outputs:
  - stat_rx: counts snooper_done handshakes;
  - stat_acc: counts cpu_acc handshakes;
  - stat_rej: counts cpu_rej handshakes.
- The counters saturate at 0xFFFFFFFF, reset to 0, and only count legal handshakes.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package packetmem_sched_pkg holds:
  - agent_state_t enum {IDLE, OWN};
  - default widths: SEL_WIDTH = 2, LEN_WIDTH = 13;
  - N_BUFS_MAX = 4.
- One sub-module, sched_idx_fifo: a parameterised index FIFO (depth, width; push/pop/empty/head) instantiated twice, for cpu_q and fwd_q.
- The length array and the free bitmap stay in the top module.

Test Plan:
- Reset release, snooper_done with len = 44 after 11 writes -> snooper_sel = 0, then ready_for_cpu rises with cpu_sel = 0, cpu_len = 44. snooper is re-granted buffer 1, 2 cycles after done.
- cpu_rej on buffer 0 -> ready_for_forwarder stays 0; buffer 0 returns to free; the next snooper grant order is 1, then 0.
- 56-byte packet accepted, forwarder_done 50 cycles later -> fwd_sel = 0, fwd_len = 56; ready_for_forwarder is high for exactly 50 cycles.
- Snooper finishes 3 packets while the CPU stalls -> ready_for_snooper is 0 after the 3rd done. After cpu_acc, the CPU sees buffers in order 0, 1, 2; snooper re-granted only after a release.
- Same cycle: cpu_rej on buffer 1 and forwarder_done on buffer 2 -> both free next cycle; lowest free index granted to the snooper.
- cpu_acc and cpu_rej together, and forwarder_done while IDLE -> proto_err = 1, buffer freed, no fwd_q push. Reset clears proto_err.
